// File: rtl/rtc_seq_pkg.sv
// Shared types for the RTC bus sequencer: FSM states, command op codes and the command record.
package rtc_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_ADR_CS, S_ADR_STB, S_ADR_HOLD, S_GAP,
        S_DAT_CS, S_DAT_STB, S_DAT_HOLD, S_DONE
    } state_e;

    typedef enum logic [1:0] {OP_NONE, OP_RD, OP_WR, OP_INIT} op_e;

    typedef struct packed {
        op_e        op;
        logic [7:0] addr;
        logic [7:0] data;
    } cmd_t;

    // Phase indices of the bus access sequence.
    localparam int PH_ADR = 0;
    localparam int PH_GAP = 1;
    localparam int PH_DAT = 2;

    // Start priority: inicio > escribir > leer.
    function automatic op_e pick_op(logic ini, logic wr, logic rd);
        if (ini)     return OP_INIT;
        else if (wr) return OP_WR;
        else if (rd) return OP_RD;
        return OP_NONE;
    endfunction

endpackage

// File: rtl/rtc_bus_sequencer_if.sv
// Decoder command port and RTC multiplexed AD bus, bundled for the sequencer.
interface rtc_bus_sequencer_if;
    logic       arranque_inicio, arranque_escribir, arranque_leer;
    logic [7:0] direccion, dato, ad_in, ad_out, dato_leido;
    logic       ad_oe, cs_n, rd_n, wr_n, a_d, listo, ocupado;

    modport master (
        output arranque_inicio, arranque_escribir, arranque_leer, direccion, dato, ad_in,
        input  ad_out, ad_oe, cs_n, rd_n, wr_n, a_d, dato_leido, listo, ocupado
    );
    modport slave (
        input  arranque_inicio, arranque_escribir, arranque_leer, direccion, dato, ad_in,
        output ad_out, ad_oe, cs_n, rd_n, wr_n, a_d, dato_leido, listo, ocupado
    );
endinterface

// File: rtl/rtc_phase_timer.sv
// Phase down-counter: reloads PHASE_CYC-1 on load_i, last_o marks the final cycle of a phase.
module rtc_phase_timer #(
    parameter int PHASE_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    output logic last_o
);
    localparam int W = $clog2(PHASE_CYC + 1);
    localparam logic [W-1:0] RELOAD = W'(PHASE_CYC - 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                cnt_q <= '0;
        else if (load_i)        cnt_q <= RELOAD;
        else if (cnt_q != '0)   cnt_q <= cnt_q - 1'b1;
    end

    assign last_o = (cnt_q == '0);
endmodule

// File: rtl/rtc_bus_sequencer.sv
// RTC multiplexed-bus sequencer: address phase, gap, data phase; init runs two writes.
// Optional one-deep pending command slot enabled with `define RTC_SEQ_QUEUE_EN.
module rtc_bus_sequencer
    import rtc_seq_pkg::*;
#(
    parameter int         PHASE_CYC  = 4,
    parameter logic [7:0] INIT_ADDR  = 8'h02,
    parameter logic [7:0] INIT_DATA0 = 8'h10,
    parameter logic [7:0] INIT_DATA1 = 8'h00
) (
    input  logic clk,
    input  logic rst,
    rtc_bus_sequencer_if.slave bus
);
    state_e     state_q, state_d;
    cmd_t       cmd_q, cmd_d;
    logic       init2_q, init2_d;
    logic       last;
    op_e        op1;

    logic       cs_n_d, rd_n_d, wr_n_d, a_d_d, ad_oe_d;
    logic [7:0] ad_out_d;
    logic       cs_n_q, rd_n_q, wr_n_q, a_d_q, ad_oe_q, listo_q, ocupado_q;
    logic [7:0] ad_out_q, dato_leido_q;

    function automatic cmd_t new_cmd(op_e op, logic [7:0] dir, logic [7:0] dat);
        new_cmd.op   = op;
        new_cmd.addr = (op == OP_INIT) ? INIT_ADDR  : dir;
        new_cmd.data = (op == OP_INIT) ? INIT_DATA0 : dat;
    endfunction

    rtc_phase_timer #(.PHASE_CYC(PHASE_CYC)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (state_d != state_q),
        .last_o (last)
    );

    assign op1 = pick_op(bus.arranque_inicio, bus.arranque_escribir, bus.arranque_leer);

`ifdef RTC_SEQ_QUEUE_EN
    cmd_t pend_q, pend_d;
    op_e  op2;
    // Runner-up of simultaneous starts goes to the slot.
    assign op2 = pick_op(1'b0, bus.arranque_escribir & bus.arranque_inicio,
                         bus.arranque_leer & (bus.arranque_inicio | bus.arranque_escribir));
`endif

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        init2_d = init2_q;
`ifdef RTC_SEQ_QUEUE_EN
        pend_d  = pend_q;
        if (state_q != S_IDLE && pend_q.op == OP_NONE)
            pend_d = new_cmd(op1, bus.direccion, bus.dato);
`endif
        case (state_q)
            S_IDLE: begin
`ifdef RTC_SEQ_QUEUE_EN
                if (pend_q.op != OP_NONE) begin
                    cmd_d   = pend_q;
                    pend_d  = '0;
                    init2_d = 1'b0;
                    state_d = S_ADR_CS;
                end else if (op1 != OP_NONE) begin
                    cmd_d   = new_cmd(op1, bus.direccion, bus.dato);
                    pend_d  = new_cmd(op2, bus.direccion, bus.dato);
                    init2_d = 1'b0;
                    state_d = S_ADR_CS;
                end
`else
                if (op1 != OP_NONE) begin
                    cmd_d   = new_cmd(op1, bus.direccion, bus.dato);
                    init2_d = 1'b0;
                    state_d = S_ADR_CS;
                end
`endif
            end
            S_DAT_HOLD: if (last) begin
                if (cmd_q.op == OP_INIT && !init2_q) begin
                    cmd_d.data = INIT_DATA1;
                    init2_d    = 1'b1;
                    state_d    = S_ADR_CS;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
`ifdef RTC_SEQ_QUEUE_EN
                if (pend_q.op != OP_NONE) begin
                    cmd_d   = pend_q;
                    pend_d  = '0;
                    init2_d = 1'b0;
                    state_d = S_ADR_CS;
                end
`endif
            end
            default: if (last) state_d = state_e'(state_q + 4'd1);
        endcase
    end

    // Outputs are decoded from the next state so the registered pins line up with the state.
    always_comb begin
        logic adr, dat, rdop;
        adr      = state_d inside {S_ADR_CS, S_ADR_STB, S_ADR_HOLD};
        dat      = state_d inside {S_DAT_CS, S_DAT_STB, S_DAT_HOLD};
        rdop     = (cmd_d.op == OP_RD);
        cs_n_d   = !(adr || dat);
        wr_n_d   = !(state_d == S_ADR_STB || (state_d == S_DAT_STB && !rdop));
        rd_n_d   = !(state_d == S_DAT_STB && rdop);
        a_d_d    = !(dat || state_d == S_GAP);
        ad_oe_d  = adr || (dat && !rdop);
        ad_out_d = adr ? cmd_d.addr : ((dat && !rdop) ? cmd_d.data : 8'h00);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cmd_q        <= '0;
            init2_q      <= 1'b0;
            cs_n_q       <= 1'b1;
            rd_n_q       <= 1'b1;
            wr_n_q       <= 1'b1;
            a_d_q        <= 1'b1;
            ad_oe_q      <= 1'b0;
            ad_out_q     <= 8'h00;
            dato_leido_q <= 8'h00;
            listo_q      <= 1'b0;
            ocupado_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            init2_q   <= init2_d;
            cs_n_q    <= cs_n_d;
            rd_n_q    <= rd_n_d;
            wr_n_q    <= wr_n_d;
            a_d_q     <= a_d_d;
            ad_oe_q   <= ad_oe_d;
            ad_out_q  <= ad_out_d;
            listo_q   <= (state_d == S_DONE);
            ocupado_q <= (state_d != S_IDLE);
            if (state_q == S_DAT_STB && last && cmd_q.op == OP_RD)
                dato_leido_q <= bus.ad_in;
        end
    end

`ifdef RTC_SEQ_QUEUE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pend_q <= '0;
        else     pend_q <= pend_d;
    end
`endif

    assign bus.cs_n       = cs_n_q;
    assign bus.rd_n       = rd_n_q;
    assign bus.wr_n       = wr_n_q;
    assign bus.a_d        = a_d_q;
    assign bus.ad_oe      = ad_oe_q;
    assign bus.ad_out     = ad_out_q;
    assign bus.dato_leido = dato_leido_q;
    assign bus.listo      = listo_q;
    assign bus.ocupado    = ocupado_q;
endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Directed bench for rtc_bus_sequencer: default timing instance plus a PHASE_CYC=1 instance.
module tb_rtc_bus_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    rtc_bus_sequencer_if bus0();
    rtc_bus_sequencer_if bus1();

    rtc_bus_sequencer #(.PHASE_CYC(4)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    rtc_bus_sequencer #(.PHASE_CYC(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start sampled at the next edge (cycle 0); returns at the cycle-1 sample point.
    task automatic start(input bit which, input bit ini, input bit wr, input bit rd,
                         input logic [7:0] dir, input logic [7:0] dat);
        if (which) begin
            bus1.arranque_inicio = ini; bus1.arranque_escribir = wr; bus1.arranque_leer = rd;
            bus1.direccion = dir; bus1.dato = dat;
        end else begin
            bus0.arranque_inicio = ini; bus0.arranque_escribir = wr; bus0.arranque_leer = rd;
            bus0.direccion = dir; bus0.dato = dat;
        end
        @(posedge clk); #1;
        bus0.arranque_inicio = 0; bus0.arranque_escribir = 0; bus0.arranque_leer = 0;
        bus1.arranque_inicio = 0; bus1.arranque_escribir = 0; bus1.arranque_leer = 0;
        // Later address/data changes must be ignored.
        bus0.direccion = 8'hFF; bus0.dato = 8'hFF; bus1.direccion = 8'hFF; bus1.dato = 8'hFF;
    endtask

    // Watches ncyc cycles from cycle 1, tallying strobes, values and listo.
    task automatic observe(input bit which, input int ncyc, input logic [7:0] rdval,
                           output int lc, output int nl, output int wa, output int wd,
                           output int rl, output int oed, output logic [7:0] av,
                           output logic [7:0] d1, output logic [7:0] dn, output logic [7:0] dl);
        logic s_cs, s_rd, s_wr, s_ad, s_oe, s_ls;
        logic [7:0] s_out, s_dl;
        bit got = 0;
        lc = -1; nl = 0; wa = 0; wd = 0; rl = 0; oed = 0;
        av = 8'hxx; d1 = 8'hxx; dn = 8'hxx; dl = 8'hxx;
        for (int c = 1; c <= ncyc; c++) begin
            s_cs  = which ? bus1.cs_n   : bus0.cs_n;
            s_rd  = which ? bus1.rd_n   : bus0.rd_n;
            s_wr  = which ? bus1.wr_n   : bus0.wr_n;
            s_ad  = which ? bus1.a_d    : bus0.a_d;
            s_oe  = which ? bus1.ad_oe  : bus0.ad_oe;
            s_ls  = which ? bus1.listo  : bus0.listo;
            s_out = which ? bus1.ad_out : bus0.ad_out;
            s_dl  = which ? bus1.dato_leido : bus0.dato_leido;
            bus0.ad_in = s_rd ? 8'hA5 : rdval;
            bus1.ad_in = s_rd ? 8'hA5 : rdval;
            if (!s_wr && s_ad)  begin wa++; av = s_out; end
            if (!s_wr && !s_ad) begin wd++; if (!got) d1 = s_out; got = 1; dn = s_out; end
            if (!s_rd) rl++;
            if (!s_cs && !s_ad && s_oe) oed++;
            if (s_ls) begin nl++; if (lc < 0) begin lc = c; dl = s_dl; end end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int lc, nl, wa, wd, rl, oed;
        logic [7:0] av, d1, dn, dl;
        bus0.arranque_inicio = 0; bus0.arranque_escribir = 0; bus0.arranque_leer = 0;
        bus1.arranque_inicio = 0; bus1.arranque_escribir = 0; bus1.arranque_leer = 0;
        bus0.direccion = 0; bus0.dato = 0; bus0.ad_in = 8'hA5;
        bus1.direccion = 0; bus1.dato = 0; bus1.ad_in = 8'hA5;

        #12;
        chk("rst_cs_n", bus0.cs_n, 1);
        chk("rst_rd_n", bus0.rd_n, 1);
        chk("rst_wr_n", bus0.wr_n, 1);
        chk("rst_a_d", bus0.a_d, 1);
        chk("rst_ad_oe", bus0.ad_oe, 0);
        chk("rst_ad_out", bus0.ad_out, 8'h00);
        chk("rst_dato_leido", bus0.dato_leido, 8'h00);
        chk("rst_listo", bus0.listo, 0);
        chk("rst_ocupado", bus0.ocupado, 0);
        rst = 0;
        @(posedge clk); #1;

        // 1: write 21 <= 45
        start(0, 0, 1, 0, 8'h21, 8'h45);
        chk("wr_ocupado_c1", bus0.ocupado, 1);
        observe(0, 35, 8'h00, lc, nl, wa, wd, rl, oed, av, d1, dn, dl);
        chk("wr_listo_cycle", lc, 29);
        chk("wr_listo_count", nl, 1);
        chk("wr_adr_strobe", wa, 4);
        chk("wr_dat_strobe", wd, 4);
        chk("wr_addr_val", av, 8'h21);
        chk("wr_data_val", dn, 8'h45);
        chk("wr_rd_strobe", rl, 0);
        chk("wr_dat_oe", oed, 12);
        chk("wr_dato_leido", bus0.dato_leido, 8'h00);

        // 2: read 23, pad returns 59
        start(0, 0, 0, 1, 8'h23, 8'h00);
        observe(0, 35, 8'h59, lc, nl, wa, wd, rl, oed, av, d1, dn, dl);
        chk("rd_listo_cycle", lc, 29);
        chk("rd_rd_strobe", rl, 4);
        chk("rd_adr_strobe", wa, 4);
        chk("rd_addr_val", av, 8'h23);
        chk("rd_dat_wr_strobe", wd, 0);
        chk("rd_dat_oe", oed, 0);
        chk("rd_dl_at_listo", dl, 8'h59);

        // 3: init, two back-to-back writes with one listo
        start(0, 1, 0, 0, 8'h77, 8'h77);
        observe(0, 65, 8'h00, lc, nl, wa, wd, rl, oed, av, d1, dn, dl);
        chk("init_listo_cycle", lc, 57);
        chk("init_listo_count", nl, 1);
        chk("init_adr_strobe", wa, 8);
        chk("init_dat_strobe", wd, 8);
        chk("init_addr", av, 8'h02);
        chk("init_data0", d1, 8'h10);
        chk("init_data1", dn, 8'h00);
        chk("init_dato_leido", bus0.dato_leido, 8'h59);

        // 4: escribir and leer together; write wins
        start(0, 0, 1, 1, 8'h30, 8'h77);
        observe(0, 65, 8'h3C, lc, nl, wa, wd, rl, oed, av, d1, dn, dl);
        chk("both_listo_cycle", lc, 29);
        chk("both_first_data", d1, 8'h77);
        chk("both_dat_strobe", wd, 4);
`ifdef RTC_SEQ_QUEUE_EN
        chk("both_listo_count", nl, 2);
        chk("both_rd_strobe", rl, 4);
        chk("both_dato_leido", bus0.dato_leido, 8'h3C);
`else
        chk("both_listo_count", nl, 1);
        chk("both_rd_strobe", rl, 0);
        chk("both_dato_leido", bus0.dato_leido, 8'h59);
`endif

        // 5: reset in the middle of a write data strobe
        start(0, 0, 1, 0, 8'h44, 8'h55);
        repeat (21) @(posedge clk);
        #1;
        chk("rstmid_pre_wr_n", bus0.wr_n, 0);
        #2 rst = 1;
        #1;
        chk("rstmid_wr_n", bus0.wr_n, 1);
        chk("rstmid_cs_n", bus0.cs_n, 1);
        chk("rstmid_ad_oe", bus0.ad_oe, 0);
        chk("rstmid_ocupado", bus0.ocupado, 0);
        #2 rst = 0;
        @(posedge clk); #1;
        observe(0, 40, 8'h00, lc, nl, wa, wd, rl, oed, av, d1, dn, dl);
        chk("rstmid_no_listo", nl, 0);
        chk("rstmid_idle", bus0.ocupado, 0);

        // 6: PHASE_CYC=1 write
        start(1, 0, 1, 0, 8'h5A, 8'hC3);
        observe(1, 12, 8'h00, lc, nl, wa, wd, rl, oed, av, d1, dn, dl);
        chk("p1_listo_cycle", lc, 8);
        chk("p1_listo_count", nl, 1);
        chk("p1_adr_strobe", wa, 1);
        chk("p1_dat_strobe", wd, 1);
        chk("p1_addr_val", av, 8'h5A);
        chk("p1_data_val", dn, 8'hC3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
